morph_frame_sequencer: RTL and testbench



---
 rtl/morph_frame_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_morph_frame_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/morph_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module     : morph_frame_sequencer
//  Description: Converts a valid/ready binary pixel stream into vsync/href
//               raster timing for the 3x3 morphology matrix generator.
//               Optional error flags are built when SEQ_ERR_EN is defined.
//  Revision   : 1.0 - initial release
// ============================================================================
module morph_frame_sequencer #(
    parameter int IMG_H_DISP = 640,
    parameter int IMG_V_DISP = 480,
    parameter int DELAY_NUM  = 10,
    parameter int H_BLANK    = 16,
    parameter int V_LEAD     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       s_bit,
    input  logic       s_sof,
    input  logic [1:0] cfg_op,
    output logic       per_img_vsync,
    output logic       per_img_href,
    output logic       per_img_bit,
    output logic [1:0] op_sel,
    output logic       busy,
    output logic       frame_done,
    output logic       err_underrun,
    output logic       err_sof
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEAD   = 3'd1;
    localparam logic [2:0] S_LINE   = 3'd2;
    localparam logic [2:0] S_HBLANK = 3'd3;
    localparam logic [2:0] S_FLUSH  = 3'd4;

    localparam logic [11:0] c_lead_last   = 12'(V_LEAD - 1);
    localparam logic [11:0] c_h_last      = 12'(IMG_H_DISP - 1);
    localparam logic [11:0] c_v_last      = 12'(IMG_V_DISP - 1);
    localparam logic [11:0] c_hb_last     = 12'(H_BLANK - 1);
    localparam logic [11:0] c_flush_last  = 12'(DELAY_NUM + IMG_H_DISP + 2);

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [11:0] r_pcnt;
    logic [11:0] r_hcnt;
    logic [11:0] r_vcnt;
    logic        w_ready;
    logic        w_done;
    logic        w_start;
    logic        r_vsync;
    logic        r_href;
    logic        r_bit;
    logic [1:0]  r_op_sel;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Non-SOF pixels are drained so the stream resyncs on the next SOF;
                // the SOF pixel itself stays upstream until the first LINE cycle.
                if (s_valid && !s_sof) begin
                    w_ready = 1'b1;
                end else if (s_valid && s_sof) begin
                    w_next_state = S_LEAD;
                end
            end
            S_LEAD: begin
                if (r_pcnt == c_lead_last) begin
                    w_next_state = S_LINE;
                end
            end
            S_LINE: begin
                w_ready = 1'b1;
                if (r_hcnt == c_h_last) begin
                    w_next_state = (r_vcnt < c_v_last) ? S_HBLANK : S_FLUSH;
                end
            end
            S_HBLANK: begin
                if (r_pcnt == c_hb_last) begin
                    w_next_state = S_LINE;
                end
            end
            S_FLUSH: begin
                if (r_pcnt == c_flush_last) begin
                    w_done       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign w_start    = (r_state == S_IDLE) && (w_next_state == S_LEAD);
    assign s_ready    = w_ready && !rst;
    assign frame_done = w_done && !rst;
    assign busy       = (r_state != S_IDLE);

    // ------------------------------------------------------------------
    // Phase, pixel and line counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt <= 12'd0;
            r_hcnt <= 12'd0;
            r_vcnt <= 12'd0;
        end else begin
            // Phase counter restarts on every state change so LEAD/HBLANK/FLUSH
            // each time their own dwell from zero.
            if ((w_next_state != r_state) || (r_state == S_IDLE)) begin
                r_pcnt <= 12'd0;
            end else begin
                r_pcnt <= r_pcnt + 12'd1;
            end

            if (w_start) begin
                r_hcnt <= 12'd0;
            end else if (r_state == S_LINE) begin
                r_hcnt <= (r_hcnt == c_h_last) ? 12'd0 : r_hcnt + 12'd1;
            end

            if (w_start) begin
                r_vcnt <= 12'd0;
            end else if ((r_state == S_HBLANK) && (w_next_state == S_LINE)) begin
                r_vcnt <= r_vcnt + 12'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered raster outputs: all follow the current state by one cycle
    // so vsync, href and bit stay mutually aligned.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vsync  <= 1'b0;
            r_href   <= 1'b0;
            r_bit    <= 1'b0;
            r_op_sel <= 2'd0;
        end else begin
            r_vsync <= (r_state != S_IDLE);
            r_href  <= (r_state == S_LINE);
            r_bit   <= (r_state == S_LINE) && s_valid && s_bit;
            if (w_start) begin
                // Reserved op code is presented downstream as bypass.
                r_op_sel <= (cfg_op == 2'd3) ? 2'd0 : cfg_op;
            end
        end
    end

    assign per_img_vsync = r_vsync;
    assign per_img_href  = r_href;
    assign per_img_bit   = r_bit;
    assign op_sel        = r_op_sel;

`ifdef SEQ_ERR_EN
    logic r_err_underrun;
    logic r_err_sof;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_underrun <= 1'b0;
            r_err_sof      <= 1'b0;
        end else if (r_state == S_LINE) begin
            if (!s_valid) begin
                r_err_underrun <= 1'b1;
            end
            // A stray SOF is flagged but the pixel flows through untouched.
            if (s_valid && s_sof && !((r_hcnt == 12'd0) && (r_vcnt == 12'd0))) begin
                r_err_sof <= 1'b1;
            end
        end
    end

    assign err_underrun = r_err_underrun;
    assign err_sof      = r_err_sof;
`else
    assign err_underrun = 1'b0;
    assign err_sof      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_morph_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module     : tb_morph_frame_sequencer
//  Description: Randomized self-checking bench for morph_frame_sequencer
//               against a frame-timeline arithmetic reference model.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_morph_frame_sequencer;

    localparam int H   = 8;
    localparam int V   = 4;
    localparam int DN  = 2;
    localparam int HB  = 4;
    localparam int VL  = 3;
    localparam int PER = H + HB;
    localparam int ACT = V * H + (V - 1) * HB;
    localparam int FL  = DN + H + 3;
    localparam int TOT = VL + ACT + FL;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic       s_bit = 1'b0;
    logic       s_sof = 1'b0;
    logic [1:0] cfg_op = 2'd0;
    logic       s_ready;
    logic       per_img_vsync;
    logic       per_img_href;
    logic       per_img_bit;
    logic [1:0] op_sel;
    logic       busy;
    logic       frame_done;
    logic       err_underrun;
    logic       err_sof;

    morph_frame_sequencer #(
        .IMG_H_DISP (H),
        .IMG_V_DISP (V),
        .DELAY_NUM  (DN),
        .H_BLANK    (HB),
        .V_LEAD     (VL)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_bit         (s_bit),
        .s_sof         (s_sof),
        .cfg_op        (cfg_op),
        .per_img_vsync (per_img_vsync),
        .per_img_href  (per_img_href),
        .per_img_bit   (per_img_bit),
        .op_sel        (op_sel),
        .busy          (busy),
        .frame_done    (frame_done),
        .err_underrun  (err_underrun),
        .err_sof       (err_sof)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_value(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: position inside a frame derived purely from the number
    // of cycles elapsed since the frame left IDLE.
    logic       m_busy = 1'b0;
    int         m_rel = 0;
    logic       m_q_vsync = 1'b0;
    logic       m_q_href = 1'b0;
    logic       m_q_bit = 1'b0;
    logic [1:0] m_q_op = 2'd0;
    logic       m_err_u = 1'b0;
    logic       m_err_s = 1'b0;
    int         frames_done = 0;

    int valid_pct = 100;
    bit want_sof = 1'b0;
    int inj_line = -1;
    int inj_pos = 0;
    int rst_line = -1;
    int rst_pos = 0;

    // 0 lead, 1 active pixel, 2 line blanking, 3 flush
    function automatic int phase_of(input int rel);
        int r2;
        if (rel < VL) return 0;
        r2 = rel - VL;
        if (r2 < ACT) return ((r2 % PER) < H) ? 1 : 2;
        return 3;
    endfunction

    task automatic step();
        int ph;
        int ln;
        int ps;
        bit e_ready;
        bit e_done;
        @(posedge clk);
        #1;
        ph = -1;
        ln = 0;
        ps = 0;
        if (m_busy) begin
            ph = phase_of(m_rel);
            if (ph == 1) begin
                ln = (m_rel - VL) / PER;
                ps = (m_rel - VL) % PER;
            end
        end
        rst = (rst_line >= 0 && ph == 1 && ln == rst_line && ps == rst_pos);
        if (rst) rst_line = -1;
        s_bit  = 1'($urandom_range(0, 1));
        cfg_op = 2'($urandom_range(0, 3));
        if (want_sof) begin
            s_valid = 1'b1;
            s_sof   = 1'b1;
        end else if (inj_line >= 0 && ph == 1 && ln == inj_line && ps == inj_pos) begin
            s_valid  = 1'b1;
            s_sof    = 1'b1;
            inj_line = -1;
        end else begin
            s_valid = ($urandom_range(0, 99) < valid_pct);
            s_sof   = 1'b0;
        end

        e_ready = !rst && ((ph == -1 && s_valid && !s_sof) || ph == 1);
        e_done  = !rst && ph == 3 && (m_rel == TOT - 1);

        @(negedge clk);
        check_value("s_ready",    12'(s_ready),       12'(e_ready));
        check_value("busy",       12'(busy),          12'(m_busy));
        check_value("frame_done", 12'(frame_done),    12'(e_done));
        check_value("vsync",      12'(per_img_vsync), 12'(m_q_vsync));
        check_value("href",       12'(per_img_href),  12'(m_q_href));
        check_value("bit",        12'(per_img_bit),   12'(m_q_bit));
        check_value("op_sel",     12'(op_sel),        12'(m_q_op));
        check_value("err_underrun", 12'(err_underrun), 12'(m_err_u));
        check_value("err_sof",    12'(err_sof),       12'(m_err_s));

        if (rst) begin
            m_busy = 1'b0; m_rel = 0;
            m_q_vsync = 1'b0; m_q_href = 1'b0; m_q_bit = 1'b0; m_q_op = 2'd0;
            m_err_u = 1'b0; m_err_s = 1'b0;
        end else begin
            m_q_vsync = m_busy;
            m_q_href  = (ph == 1);
            m_q_bit   = (ph == 1) && s_valid && s_bit;
`ifdef SEQ_ERR_EN
            if (ph == 1 && !s_valid) m_err_u = 1'b1;
            if (ph == 1 && s_valid && s_sof && m_rel != VL) m_err_s = 1'b1;
`endif
            if (ph == 1 && s_valid && s_sof && want_sof) want_sof = 1'b0;
            if (!m_busy) begin
                if (s_valid && s_sof) begin
                    m_busy = 1'b1;
                    m_rel  = 0;
                    m_q_op = (cfg_op == 2'd3) ? 2'd0 : cfg_op;
                end
            end else if (e_done) begin
                m_busy = 1'b0;
                frames_done++;
            end else begin
                m_rel++;
            end
        end
    endtask

    task automatic run_until_frames(input int target, input string tag);
        for (int i = 0; i < 400 && frames_done < target; i++) step();
        check_value(tag, 12'(frames_done), 12'(target));
    endtask

    // Independent raster-shape monitor: run lengths of vsync and href.
    int vs_run = 0;
    int hr_run = 0;
    int hr_cnt = 0;
    bit seen_href = 1'b0;
    bit aborted = 1'b1;

    always @(negedge clk) begin
        if (per_img_vsync === 1'b1 && vs_run == 0) aborted = 1'b0;
        if (rst) aborted = 1'b1;
        if (per_img_href === 1'b1) begin
            hr_run++;
        end else if (hr_run > 0) begin
            if (!aborted) check_value("href_len", 12'(hr_run), 12'(H));
            hr_cnt++;
            hr_run = 0;
        end
        if (per_img_vsync === 1'b1) begin
            vs_run++;
            if (!seen_href && per_img_href === 1'b1) begin
                if (!aborted) check_value("lead_len", 12'(vs_run - 1), 12'(VL));
                seen_href = 1'b1;
            end
        end else if (vs_run > 0) begin
            if (!aborted) begin
                check_value("vsync_len", 12'(vs_run), 12'(TOT));
                check_value("href_count", 12'(hr_cnt), 12'(V));
            end
            vs_run = 0;
            hr_cnt = 0;
            seen_href = 1'b0;
        end
    end

    initial begin
        rst     = 1'b1;
        s_valid = 1'b1;
        s_sof   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("rst_s_ready", 12'(s_ready),       12'd0);
        check_value("rst_vsync",   12'(per_img_vsync), 12'd0);
        check_value("rst_href",    12'(per_img_href),  12'd0);
        check_value("rst_bit",     12'(per_img_bit),   12'd0);
        check_value("rst_op_sel",  12'(op_sel),        12'd0);
        check_value("rst_busy",    12'(busy),          12'd0);
        check_value("rst_done",    12'(frame_done),    12'd0);
        check_value("rst_errs",    12'({err_underrun, err_sof}), 12'd0);

        // Junk pixels in IDLE are drained, then a clean frame with no gaps.
        valid_pct = 100;
        repeat (6) step();
        want_sof = 1'b1;
        run_until_frames(1, "frame1_done");

        // Frame with random underruns.
        valid_pct = 80;
        want_sof  = 1'b1;
        run_until_frames(2, "frame2_done");

        // Back-to-back: next SOF presented while the current frame flushes.
        valid_pct = 100;
        want_sof  = 1'b1;
        for (int i = 0; i < 400 && !(m_busy && phase_of(m_rel) == 3); i++) step();
        check_value("reach_flush", 12'(m_busy && phase_of(m_rel) == 3), 12'd1);
        want_sof = 1'b1;
        run_until_frames(4, "b2b_done");

        // Reset in the middle of the second line, then a full clean frame.
        want_sof = 1'b1;
        rst_line = 1;
        rst_pos  = 3;
        for (int i = 0; i < 400 && rst_line >= 0; i++) step();
        check_value("rst_hit", 12'(rst_line == -1), 12'd1);
        repeat (3) step();
        want_sof = 1'b1;
        run_until_frames(5, "post_rst_done");

        // Stray SOF inside the first line.
        want_sof = 1'b1;
        inj_line = 0;
        inj_pos  = 3;
        run_until_frames(6, "stray_sof_done");

        valid_pct = 50;
        repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
